// File: rtl/alu_op_if.sv
// Operand/opcode/result bundle for the registered byte ALU.
// The master drives operands and opcode; the slave returns the registered result.
interface alu_op_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         SEL_BIT;
    logic [2*WIDTH-1:0] OUT;

    modport master (
        output A,
        output B,
        output SEL_BIT,
        input  OUT
    );

    modport slave (
        input  A,
        input  B,
        input  SEL_BIT,
        output OUT
    );
endinterface

// File: rtl/alu_op.sv
// Registered unsigned ALU: add/sub/mul/div/logic/shift on WIDTH-bit operands,
// double-width result presented one cycle after the operands are sampled.
module alu_op #(
    parameter int WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    alu_op_if.slave  bus
);

    localparam int OUT_W = 2 * WIDTH;

    logic [OUT_W-1:0] res_p0;
    logic [OUT_W-1:0] res_p1;

    function automatic logic [OUT_W-1:0] alu_f(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       sel
    );
        logic [OUT_W-1:0] ax;
        logic [OUT_W-1:0] bx;
        logic [OUT_W-1:0] r;
        ax = {{WIDTH{1'b0}}, a};
        bx = {{WIDTH{1'b0}}, b};
        case (sel)
            3'b000: r = ax + bx;
            3'b001: r = ax - bx;
            3'b010: r = ax * bx;
            3'b011: begin
                // Division by zero returns an all-ones marker instead of a quotient.
                if (b == '0) r = '1;
                else         r = {a % b, a / b};
            end
            3'b100: r = {{WIDTH{1'b0}}, a & b};
            3'b101: r = {{WIDTH{1'b0}}, a | b};
            3'b110: r = {{WIDTH{1'b0}}, a ^ b};
            3'b111: r = ax << b[3:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    // p0: combinational result from the current operands
    always_comb begin
        res_p0 = alu_f(bus.A, bus.B, bus.SEL_BIT);
    end

    // p1: result register, cleared asynchronously by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) res_p1 <= '0;
        else     res_p1 <= res_p0;
    end

    assign bus.OUT = res_p1;

endmodule

// File: tb/tb_alu_op.sv
// Directed bench for alu_op: reset behaviour, per-opcode boundary vectors and
// a back-to-back opcode sweep against a reference model.
module tb_alu_op;

    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    alu_op_if #(.WIDTH(8)) bus ();

    alu_op #(.WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] model(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [2:0] sel
    );
        logic [15:0] r;
        unique case (sel)
            3'd0: r = 16'(a) + 16'(b);
            3'd1: r = 16'(a) - 16'(b);
            3'd2: r = 16'(a) * 16'(b);
            3'd3: r = (b == 8'd0) ? 16'hFFFF : {8'(a % b), 8'(a / b)};
            3'd4: r = {8'h00, a & b};
            3'd5: r = {8'h00, a | b};
            3'd6: r = {8'h00, a ^ b};
            default: r = 16'(a) << b[3:0];
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (bus.OUT === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, bus.OUT, exp);
        end
    endtask

    // Drive operands mid-cycle, let one edge capture them, then check just after it.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                        input string tag, input logic [15:0] exp);
        @(negedge CLK);
        bus.A       = a;
        bus.B       = b;
        bus.SEL_BIT = sel;
        @(posedge CLK);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        checks   = 0;
        failures = 0;
        RST         = 1'b1;
        bus.A       = 8'h00;
        bus.B       = 8'h00;
        bus.SEL_BIT = 3'd0;
        #1;
        check("reset_initial", 16'h0000);

        @(negedge CLK);
        RST = 1'b0;
        step(8'hE9, 8'h14, 3'd2, "preload_1234", 16'h1234);

        // Asynchronous assertion away from any clock edge
        #3;
        RST = 1'b1;
        #1;
        check("async_reset", 16'h0000);

        bus.A       = 8'hFF;
        bus.B       = 8'hFF;
        bus.SEL_BIT = 3'd2;
        @(posedge CLK);
        #1;
        check("reset_hold_1", 16'h0000);
        @(posedge CLK);
        #1;
        check("reset_hold_2", 16'h0000);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("reset_release", 16'hFE01);

        step(8'hFF, 8'h01, 3'd0, "add_carry",   16'h0100);
        step(8'h01, 8'h02, 3'd1, "sub_borrow",  16'hFFFF);
        step(8'h80, 8'h80, 3'd1, "sub_equal",   16'h0000);
        step(8'hFF, 8'hFF, 3'd2, "mul_max",     16'hFE01);
        step(8'd200, 8'd7, 3'd3, "div_200_7",   16'h041C);
        step(8'h55, 8'h00, 3'd3, "div_by_zero", 16'hFFFF);
        step(8'hF0, 8'h3C, 3'd4, "and",         16'h0030);
        step(8'hF0, 8'h3C, 3'd5, "or",          16'h00FC);
        step(8'hF0, 8'h3C, 3'd6, "xor",         16'h00CC);
        step(8'h81, 8'h04, 3'd7, "shl_4",       16'h0810);
        step(8'h81, 8'h0F, 3'd7, "shl_15",      16'h8000);
        step(8'h81, 8'h14, 3'd7, "shl_hi_nib",  16'h0810);

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            step(ra, rb, 3'(i), $sformatf("sweep_sel%0d", i), model(ra, rb, 3'(i)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
